ps2_scancode_decoder: RTL and testbench

Downstream of the PS/2 frame receiver. Consumes received bytes (Set 2 scancodes) and collapses E0/F0/E1 prefix sequences into single key events. Each event carries the code, a break flag and an extended flag. Events are buffered in a FIFO behind a valid/ready interface to the system side. The block also flags the keyboard self-test pass byte (0xAA) and drops protocol bytes.

---
 rtl/ps2_scancode_decoder.sv | 95 +++++++++
 tb/tb_ps2_scancode_decoder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: collapses Set 2 prefix sequences into key events queued in a FWFT FIFO
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_error,
  output logic [7:0]       evt_code,
  output logic             evt_break,
  output logic             evt_ext,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             kbd_reset,
  output logic             overflow,
  output logic [CNT_W-1:0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] IDLE = 3'd0, EXT = 3'd1, BRK = 3'd2, EXT_BRK = 3'd3, PAUSE = 3'd4;
  logic [2:0] state, nxt_state, pcnt, nxt_pcnt;
  logic push_req, kbd_nxt, is_proto, full, pop, wr_en;
  logic [9:0] push_word;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign is_proto = rx_data inside {8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  always_comb begin
    nxt_state = state;
    nxt_pcnt = pcnt;
    push_req = 1'b0;
    push_word = {rx_data, 2'b00};
    kbd_nxt = 1'b0;
    if (rx_error) begin
      nxt_state = IDLE;
      nxt_pcnt = 3'd0;
    end else if (rx_valid) begin
      case (state)
        IDLE: begin
          nxt_state = rx_data == 8'hE0 ? EXT : rx_data == 8'hF0 ? BRK : rx_data == 8'hE1 ? PAUSE : IDLE;
          nxt_pcnt = rx_data == 8'hE1 ? 3'd7 : pcnt;
          kbd_nxt = rx_data == 8'hAA;
          push_req = !(rx_data inside {8'hE0, 8'hF0, 8'hE1, 8'hAA}) && !is_proto;
        end
        EXT: begin
          nxt_state = rx_data == 8'hF0 ? EXT_BRK : rx_data == 8'hE0 ? EXT : IDLE;
          push_req = !(rx_data inside {8'hF0, 8'hE0, 8'h12});
          push_word = {rx_data, 2'b01};
        end
        BRK: begin
          nxt_state = rx_data == 8'hF0 ? BRK : IDLE;
          push_req = rx_data != 8'hF0;
          push_word = {rx_data, 2'b10};
        end
        EXT_BRK: begin
          nxt_state = IDLE;
          push_req = rx_data != 8'h12;
          push_word = {rx_data, 2'b11};
        end
        PAUSE: begin
          nxt_pcnt = pcnt - 3'd1;
          nxt_state = pcnt <= 3'd1 ? IDLE : PAUSE;
          push_req = pcnt <= 3'd1;
          push_word = {8'hE1, 2'b01};
        end
        default: nxt_state = IDLE;
      endcase
    end
  end
  assign full = fifo_count == CNT_W'(FIFO_DEPTH);
  assign evt_valid = fifo_count != '0;
  assign pop = evt_valid & evt_ready;
  assign wr_en = push_req & (!full | pop);
  assign {evt_code, evt_break, evt_ext} = evt_valid ? mem[rd_ptr] : 10'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pcnt <= 3'd0;
      kbd_reset <= 1'b0;
      overflow <= 1'b0;
      fifo_count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= nxt_state;
      pcnt <= nxt_pcnt;
      kbd_reset <= kbd_nxt;
      overflow <= overflow | (push_req & full & !pop);
      fifo_count <= fifo_count + CNT_W'(wr_en) - CNT_W'(pop);
      wr_ptr <= wr_en ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
    end
  end
  always_ff @(posedge clk) if (!rst && wr_en) mem[wr_ptr] <= push_word;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_ps2_scancode_decoder;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0, rx_error = 1'b0, evt_ready = 1'b1;
  logic [7:0] evt_code;
  logic evt_break, evt_ext, evt_valid, kbd_reset, overflow;
  logic [3:0] fifo_count;
  logic [9:0] q[$];
  int checks = 0, failures = 0, kbd_cnt = 0, k0 = 0;
  ps2_scancode_decoder #(.FIFO_DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
    .evt_code(evt_code), .evt_break(evt_break), .evt_ext(evt_ext), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .kbd_reset(kbd_reset), .overflow(overflow), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    logic [9:0] e;
    if (kbd_reset) kbd_cnt++;
    if (!rst && evt_valid && evt_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event got=%h/%b/%b exp=none", evt_code, evt_break, evt_ext);
      end else begin
        e = q.pop_front();
        if ({evt_code, evt_break, evt_ext} !== e) begin
          failures++;
          $display("FAIL event got=%h/%b/%b exp=%h/%b/%b", evt_code, evt_break, evt_ext, e[9:2], e[1], e[0]);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic expect_evt(input logic [7:0] c, input logic b, input logic x);
    q.push_back({c, b, x});
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask
  task automatic send_seq(input logic [7:0] s[]);
    foreach (s[i]) send(s[i]);
  endtask
  task automatic drain(input string name);
    int n = 0;
    evt_ready = 1'b1;
    while ((q.size() != 0 || evt_valid) && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk({name, "_drained"}, {31'd0, evt_valid}, 32'd0);
    chk({name, "_queue_empty"}, q.size(), 32'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", {31'd0, evt_valid}, 0);
    chk("rst_kbd", {31'd0, kbd_reset}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_count", {28'd0, fifo_count}, 0);
    chk("rst_head", {22'd0, evt_code, evt_break, evt_ext}, 0);
    expect_evt(8'h1C, 0, 0);
    send(8'h1C);
    chk("make_latency", {31'd0, evt_valid}, 1);
    expect_evt(8'h1C, 1, 0);
    send_seq('{8'hF0, 8'h1C});
    drain("makebreak");
    expect_evt(8'h75, 0, 1);
    expect_evt(8'h75, 1, 1);
    send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12});
    drain("ext");
    expect_evt(8'h1D, 0, 0);
    send(8'h1D);
    drain("fake_shift_idle");
    k0 = kbd_cnt;
    send_seq('{8'hAA, 8'hFA, 8'hEE, 8'hFE});
    repeat (2) @(posedge clk);
    #1 chk("bat_pulses", kbd_cnt - k0, 1);
    chk("bat_count", {28'd0, fifo_count}, 0);
    expect_evt(8'hAA, 1, 0);
    send_seq('{8'hF0, 8'hAA});
    drain("shift_break");
    chk("shift_break_no_kbd", kbd_cnt - k0, 1);
    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0});
    chk("pause_pending", {28'd0, fifo_count}, 0);
    expect_evt(8'hE1, 0, 1);
    send(8'h77);
    chk("pause_last", {31'd0, evt_valid}, 1);
    drain("pause");
    evt_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) expect_evt(8'(i), 0, 0);
      send(8'(i));
    end
    chk("ovf_count", {28'd0, fifo_count}, 8);
    chk("ovf_flag", {31'd0, overflow}, 1);
    repeat (3) @(posedge clk);
    #1 chk("ovf_head_stable", {24'd0, evt_code}, 8'h01);
    drain("ovf");
    chk("ovf_sticky", {31'd0, overflow}, 1);
    send(8'hE0);
    rx_error = 1'b1;
    @(posedge clk);
    #1 rx_error = 1'b0;
    expect_evt(8'h1C, 0, 0);
    send(8'h1C);
    drain("err");
    send(8'hF0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_clears_ovf", {31'd0, overflow}, 0);
    expect_evt(8'h1C, 0, 0);
    send(8'h1C);
    drain("rst_mid");
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_evt(8'h31 + 8'(i), 0, 0);
      send(8'h31 + 8'(i));
    end
    chk("full_count", {28'd0, fifo_count}, 8);
    evt_ready = 1'b1;
    rx_data = 8'h40;
    rx_valid = 1'b1;
    expect_evt(8'h40, 0, 0);
    @(posedge clk);
    #1 rx_valid = 1'b0;
    evt_ready = 1'b0;
    chk("pushpop_count", {28'd0, fifo_count}, 8);
    chk("pushpop_no_ovf", {31'd0, overflow}, 0);
    chk("pushpop_head", {24'd0, evt_code}, 8'h32);
    drain("pushpop");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
